// File: rtl/dr_pkg.sv
// Shared defaults and pointer-width helper for the data-register FIFO.
package dr_pkg;
  localparam int DR_WIDTH_DEF = 8;
  localparam int DR_DEPTH_DEF = 4;

  function automatic int dr_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/dr_ram.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port, no reset.
module dr_ram
  import dr_pkg::*;
#(
  parameter int WIDTH = DR_WIDTH_DEF,
  parameter int DEPTH = DR_DEPTH_DEF,
  parameter int AW    = dr_aw(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;

  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    always_ff @(posedge clk) begin
      if (we && waddr == AW'(e)) mem[e] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/dr_fifo.sv
// DEPTH-entry data-register queue between memory (IDR loads) and the internal bus (EDR emits),
// with registered output word, occupancy status and sticky overflow/underflow flags.
module dr_fifo
  import dr_pkg::*;
#(
  parameter int WIDTH = DR_WIDTH_DEF,
  parameter int DEPTH = DR_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     IDR,
  input  logic                     EDR,
  input  logic [WIDTH-1:0]         Din,
  output logic [WIDTH-1:0]         Dout,
  output logic                     Dout_valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  output logic                     udf
);
  localparam int AW = dr_aw(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] rdata;
  logic             push, pop, flush;

  assign flush = rst | clr;
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  // A pop frees the slot the same edge, so a full queue still accepts a push alongside a pop.
  assign pop   = EDR & ~empty;
  assign push  = IDR & (~full | pop);

  dr_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (push & ~flush),
    .waddr (wr_ptr),
    .wdata (Din),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      Dout       <= '0;
      Dout_valid <= 1'b0;
      ovf        <= 1'b0;
      udf        <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count      <= count + CW'(push) - CW'(pop);
      Dout       <= pop ? rdata : '0;
      Dout_valid <= pop;
      if (IDR & ~push) ovf <= 1'b1;
      if (EDR & empty) udf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dr_fifo.sv
// Scoreboarded bench for dr_fifo: directed scenarios plus random traffic against a queue model.
module tb_dr_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1, clr = 1'b0, IDR = 1'b0, EDR = 1'b0;
  logic [WIDTH-1:0] Din = '0;
  logic [WIDTH-1:0] Dout;
  logic             Dout_valid, full, empty, ovf, udf;
  logic [$clog2(DEPTH):0] count;

  int errors = 0;
  int checks = 0;

  int  model_q[$];
  int  exp_q[$];
  bit  m_ovf, m_udf, m_valid;

  always #5 clk = ~clk;

  dr_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clr(clr), .IDR(IDR), .EDR(EDR), .Din(Din),
    .Dout(Dout), .Dout_valid(Dout_valid), .full(full), .empty(empty),
    .count(count), .ovf(ovf), .udf(udf)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, advance the model, check status just after the edge.
  task automatic step(input bit r, input bit c, input bit i, input bit e, input int d);
    bit p, w;
    @(negedge clk);
    rst = r; clr = c; IDR = i; EDR = e; Din = WIDTH'(d);
    if (r || c) begin
      model_q.delete();
      m_ovf = 0; m_udf = 0; m_valid = 0;
    end else begin
      p = e && (model_q.size() > 0);
      w = i && (model_q.size() < DEPTH || p);
      if (e && model_q.size() == 0) m_udf = 1;
      if (i && !w) m_ovf = 1;
      if (p) exp_q.push_back(model_q.pop_front());
      if (w) model_q.push_back(d & 8'hFF);
      m_valid = p;
    end
    @(posedge clk);
    #1;
    chk("count", int'(count), model_q.size());
    chk("empty", int'(empty), int'(model_q.size() == 0));
    chk("full", int'(full), int'(model_q.size() == DEPTH));
    chk("ovf", int'(ovf), int'(m_ovf));
    chk("udf", int'(udf), int'(m_udf));
    chk("dout_valid", int'(Dout_valid), int'(m_valid));
  endtask

  // Monitor: data leaving the DUT is matched against the scoreboard in order.
  always @(negedge clk) begin
    if (Dout_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_pop", int'(Dout), -1);
      else chk("dout_data", int'(Dout), exp_q.pop_front());
    end else if (!rst || $time > 20) begin
      chk("dout_idle_zero", int'(Dout), 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset, single push, single pop
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 8'h13);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    // 2: fill, overflow attempt, drain
    for (int k = 0; k < 4; k++) step(0, 0, 1, 0, 8'h10 + k);
    step(0, 0, 1, 0, 8'h14);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    // 3: push+pop while full
    for (int k = 0; k < 4; k++) step(0, 0, 1, 0, 8'h10 + k);
    step(0, 0, 1, 1, 8'hAA);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 0);
    // 4: push+pop while empty -> no fall-through
    step(0, 0, 1, 1, 8'h55);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    // 5: staggered wrap
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1);
    for (int k = 2; k < 10; k++) step(0, 0, 1, 1, k);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    // 6: flush mid-operation, then underflow only
    for (int k = 0; k < 3; k++) step(0, 0, 1, 0, 8'h20 + k);
    step(0, 1, 1, 0, 8'h77);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    // Random traffic with occasional flushes
    for (int n = 0; n < 600; n++) begin
      step(0, ($urandom_range(0, 79) == 0), ($urandom_range(0, 99) < 55),
           ($urandom_range(0, 99) < 50), int'($urandom_range(0, 255)));
    end
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
